// File: rtl/cdb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_rr_arbiter
//
// Purpose:
//   Chooses at most one pending functional-unit result per cycle and
//   registers it onto the common data bus (CDB) broadcast register. The
//   winner also gets a one-cycle grant pulse so it can retire its entry.
//
// Configuration macro:
//   CDB_RR_FAIR_EN  defined   -> round-robin arbitration with a rotating
//                                search pointer
//                   undefined -> fixed priority, lowest eligible index wins
//                                (no pointer register)
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset, clears pointer and outputs
//   req_valid  per-requester "result ready" flags
//   req_tag    packed ROB tags, requester i at [i*TAG_W +: TAG_W]
//   req_data   packed results, requester i at [i*DATA_W +: DATA_W]
//   flush      mispredict flush, cancels this cycle's arbitration
//   grant      registered one-hot pulse naming the requester on the bus
//   cdb_valid  registered broadcast valid
//   cdb_tag    registered broadcast tag
//   cdb_data   registered broadcast data
//   cdb_src    index of the requester currently driving the bus
// ---------------------------------------------------------------------------
module cdb_rr_arbiter #(
  parameter int N      = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*TAG_W-1:0]    req_tag,
  input  logic [N*DATA_W-1:0]   req_data,
  input  logic                  flush,
  output logic [N-1:0]          grant,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_data,
  output logic [$clog2(N)-1:0]  cdb_src
);

  localparam int SRC_W = $clog2(N);

  // A requester that is on the bus right now is still holding its valid
  // until the end of this cycle, so it must not be picked again.
  logic [N-1:0] eligible;
  assign eligible = req_valid & ~grant;

  logic             win_found;
  logic [SRC_W-1:0] win_idx;

`ifdef CDB_RR_FAIR_EN
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] ptr_next;

  // Circular search from ptr without a modulo: first take the lowest
  // eligible index overall (covers the wrapped part 0..ptr-1), then let
  // the lowest eligible index at or above ptr override it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i] && (SRC_W'(i) >= ptr)) begin
        win_idx = SRC_W'(i);
      end
    end
  end

  // Pointer moves just past the winner, wrapping N-1 back to 0.
  assign ptr_next = (win_idx == SRC_W'(N - 1)) ? '0 : win_idx + SRC_W'(1);

  // The pointer only advances on a real broadcast; flushed or idle
  // cycles leave the fairness order untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (!flush && win_found) begin
      ptr <= ptr_next;
    end
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(i);
      end
    end
  end
`endif

  // Select the winner's tag and data and form its one-hot grant vector.
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [N-1:0]      win_onehot;

  always_comb begin
    win_tag    = '0;
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (SRC_W'(i) == win_idx) begin
        win_tag       = req_tag[i*TAG_W +: TAG_W];
        win_data      = req_data[i*DATA_W +: DATA_W];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Broadcast register. Reset beats flush, flush beats any request, and an
  // idle or cancelled cycle drives the whole bus to zero rather than
  // holding the previous broadcast.
  always_ff @(posedge clk) begin
    if (rst || flush || !win_found) begin
      grant     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      grant     <= win_onehot;
      cdb_valid <= 1'b1;
      cdb_tag   <= win_tag;
      cdb_data  <= win_data;
      cdb_src   <= win_idx;
    end
  end

endmodule
